// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXIS packet generator.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // TUSER bit that marks the first beat of a packet
  localparam int SOF_BIT = 0;

  // Widest TKEEP the mask helper can produce (1024-bit TDATA)
  localparam int KEEP_MAX = 128;

  // Low r lanes set; r at or above the lane count gives a full mask
  function automatic logic [KEEP_MAX-1:0] keep_from_bytes(input int unsigned r);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      m[i] = (i < r);
    end
    return m;
  endfunction

  // Byte k of packet p: wraps naturally at 8 bits
  function automatic logic [7:0] pattern_byte(input logic [7:0] p, input logic [7:0] k);
    return p + k;
  endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle between the packet generator and its sink.
interface axis_pkt_gen_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pkt_beat_fmt.sv
// Builds one beat (data, keep, last) from packet base byte, beat index and bytes left.
module axis_pkt_beat_fmt
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int LEN_W  = 16
) (
  input  logic [7:0]        i_base,
  input  logic [LEN_W-1:0]  i_beat,
  input  logic [LEN_W:0]    i_rem,
  output logic [DATA_W-1:0] o_tdata,
  output logic [KEEP_W-1:0] o_tkeep,
  output logic              o_tlast
);

  logic [7:0] w_off;

  // only the low byte of the lane offset matters for the mod-256 pattern
  assign w_off   = 8'(i_beat * KEEP_W);
  assign o_tkeep = KEEP_W'(keep_from_bytes(32'(i_rem)));
  assign o_tlast = (i_rem <= (LEN_W + 1)'(KEEP_W));

  // fill enabled lanes with the pattern, masked lanes stay zero
  always_comb begin
    o_tdata = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (o_tkeep[i]) o_tdata[i*8 +: 8] = pattern_byte(i_base, w_off + 8'(i));
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet source: programmed count of patterned packets with optional gaps.
//
//  state | meaning
//  IDLE  | waiting for start; bad config flags cfg_err and pulses done
//  SEND  | presenting beats, stalls on tready low
//  GAP   | tvalid low for cfg_gap cycles between packets
//  DONE  | one-cycle done pulse, then back to IDLE
module axis_pkt_gen
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pkts_sent,
  axis_pkt_gen_if.master   m_axis
);

  localparam logic [LEN_W:0] REM_STEP = (LEN_W + 1)'(KEEP_W);

  state_t r_state, w_state_nxt;

  logic [LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [LEN_W-1:0]  r_beat;
  logic [LEN_W:0]    r_rem;
  logic [CNT_W-1:0]  r_pkts_sent;
  logic              r_busy, r_done, r_cfg_err;
  logic              r_tvalid, r_tlast;
  logic [DATA_W-1:0] r_tdata;
  logic [KEEP_W-1:0] r_tkeep;
  logic [USER_W-1:0] r_tuser;

  logic              w_hs;
  logic              w_load, w_start_ok, w_start_err, w_pkt_done, w_gap_load;
  logic [CNT_W-1:0]  w_sent_inc;
  logic [7:0]        w_fmt_base;
  logic [LEN_W-1:0]  w_fmt_beat;
  logic [LEN_W:0]    w_fmt_rem;
  logic [DATA_W-1:0] w_fmt_data;
  logic [KEEP_W-1:0] w_fmt_keep;
  logic              w_fmt_last;
  logic [USER_W-1:0] w_fmt_user;

  assign w_hs       = r_tvalid && m_axis.tready;
  assign w_sent_inc = r_pkts_sent + 1'b1;

  axis_pkt_beat_fmt #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .LEN_W  (LEN_W)
  ) u_fmt (
    .i_base  (w_fmt_base),
    .i_beat  (w_fmt_beat),
    .i_rem   (w_fmt_rem),
    .o_tdata (w_fmt_data),
    .o_tkeep (w_fmt_keep),
    .o_tlast (w_fmt_last)
  );

  // next state and selection of the beat to load into the output registers
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start_ok  = 1'b0;
    w_start_err = 1'b0;
    w_pkt_done  = 1'b0;
    w_gap_load  = 1'b0;
    w_fmt_base  = 8'(r_pkts_sent);
    w_fmt_beat  = '0;
    w_fmt_rem   = {1'b0, r_len};
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0 && cfg_count != '0) begin
            w_start_ok  = 1'b1;
            w_load      = 1'b1;
            w_fmt_base  = 8'h00;
            w_fmt_rem   = {1'b0, cfg_len};
            w_state_nxt = SEND;
          end else begin
            w_start_err = 1'b1;
          end
        end
      end
      SEND: begin
        if (w_hs) begin
          if (r_tlast) begin
            w_pkt_done = 1'b1;
            if (w_sent_inc == r_count) begin
              w_state_nxt = DONE;
            end else if (r_gap == '0) begin
              w_load     = 1'b1;
              w_fmt_base = 8'(w_sent_inc);
            end else begin
              w_gap_load  = 1'b1;
              w_state_nxt = GAP;
            end
          end else begin
            w_load     = 1'b1;
            w_fmt_beat = r_beat + 1'b1;
            w_fmt_rem  = r_rem - REM_STEP;
          end
        end
      end
      GAP: begin
        // pkts_sent already points at the upcoming packet here
        if (r_gap_cnt == GAP_W'(1)) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_fmt_user          = '0;
    w_fmt_user[SOF_BIT] = (w_fmt_beat == '0);
  end

  // state, run configuration, counters and status flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_pkts_sent <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == SEND) || (w_state_nxt == GAP);
      r_done  <= w_start_err || (r_state == SEND && w_state_nxt == DONE);
      if (w_start_err) r_cfg_err <= 1'b1;
      if (w_start_ok) begin
        r_cfg_err   <= 1'b0;
        r_len       <= cfg_len;
        r_count     <= cfg_count;
        r_gap       <= cfg_gap;
        r_pkts_sent <= '0;
      end
      if (w_pkt_done) r_pkts_sent <= w_sent_inc;
      if (w_gap_load) r_gap_cnt <= r_gap;
      else if (r_state == GAP) r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // AXIS output registers: load a new beat, or drop valid after the last transfer
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= '0;
      r_beat   <= '0;
      r_rem    <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_fmt_data;
      r_tkeep  <= w_fmt_keep;
      r_tlast  <= w_fmt_last;
      r_tuser  <= w_fmt_user;
      r_beat   <= w_fmt_beat;
      r_rem    <= w_fmt_rem;
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign cfg_err       = r_cfg_err;
  assign pkts_sent     = r_pkts_sent;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen with a 32-bit stream.
module tb_axis_pkt_gen;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int USER_W = 1;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;
  localparam int GAP_W  = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic             aclk    = 1'b0;
  logic             aresetn = 1'b1;
  logic             start   = 1'b0;
  logic [LEN_W-1:0] cfg_len   = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic [GAP_W-1:0] cfg_gap   = '0;
  logic             busy, done, cfg_err;
  logic [CNT_W-1:0] pkts_sent;

  axis_pkt_gen_if #(.DATA_W(DATA_W), .USER_W(USER_W)) m_axis_if ();

  axis_pkt_gen #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W),
    .GAP_W  (GAP_W)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_count (cfg_count),
    .cfg_gap   (cfg_gap),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .pkts_sent (pkts_sent),
    .m_axis    (m_axis_if)
  );

  always #5 aclk = ~aclk;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  int    cyc = 0, valid_cyc = 0, hs_cnt = 0, done_cnt = 0, done_base = 0;
  int    done_cyc = 0, last_hs_cyc = 0, gap_meas = -1, gap_run = 0;
  bit    gap_count = 0, prev_stall = 0, rdy_rand = 0;
  beat_t prev_bus;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_run(input int len, input int count);
    for (int p = 0; p < count; p++) begin
      int beats;
      beats = (len + KEEP_W - 1) / KEEP_W;
      for (int b = 0; b < beats; b++) begin
        beat_t x;
        x = '0;
        for (int i = 0; i < KEEP_W; i++) begin
          int k;
          k = b * KEEP_W + i;
          if (k < len) begin
            x.keep[i]       = 1'b1;
            x.data[i*8 +: 8] = 8'((p + k) % 256);
          end
        end
        x.last = (b == beats - 1);
        x.user = (b == 0);
        exp_q.push_back(x);
      end
    end
  endtask

  // stream monitor: scoreboard pop, stall stability, gap and done timing
  always @(negedge aclk) begin
    beat_t cur, e;
    cyc++;
    cur = {m_axis_if.tdata, m_axis_if.tkeep, m_axis_if.tlast, m_axis_if.tuser[0]};
    if (!aresetn) begin
      prev_stall = 1'b0;
      gap_count  = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", m_axis_if.tvalid, 1);
        check_val("hold_beat", cur, prev_bus);
      end
      if (m_axis_if.tvalid) valid_cyc++;
      if (gap_count) begin
        if (m_axis_if.tvalid) begin
          gap_meas  = gap_run;
          gap_count = 1'b0;
        end else begin
          gap_run++;
        end
      end
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("tdata", cur.data, e.data);
          check_val("keep_last_user", {cur.keep, cur.last, cur.user}, {e.keep, e.last, e.user});
        end
        if (cur.last) begin
          last_hs_cyc = cyc;
          gap_count   = 1'b1;
          gap_run     = 0;
        end
      end
      prev_stall = m_axis_if.tvalid && !m_axis_if.tready;
      prev_bus   = cur;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // sink ready: always ready, or a coin toss each cycle
  initial begin
    m_axis_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_start(input int len, input int count, input int gap, input bit ok);
    @(posedge aclk);
    #1;
    cfg_len   = LEN_W'(len);
    cfg_count = CNT_W'(count);
    cfg_gap   = GAP_W'(gap);
    start     = 1'b1;
    if (ok) push_run(len, count);
    valid_cyc = 0;
    gap_count = 1'b0;
    gap_meas  = -1;
    done_base = done_cnt;
    @(posedge aclk);
    #1;
    start     = 1'b0;
    cfg_len   = LEN_W'($urandom);
    cfg_count = CNT_W'($urandom);
    cfg_gap   = GAP_W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check_val("done_seen", 64'(done_cnt != done_base), 1);
    check_val("busy_at_done", busy, 0);
    @(negedge aclk);
    #1;
    check_val("done_one_cycle", done, 0);
    check_val("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2 aresetn = 1'b0;
    #10;
    check_val("rst_tvalid", m_axis_if.tvalid, 0);
    check_val("rst_tdata", m_axis_if.tdata, 0);
    check_val("rst_tkeep_last_user", {m_axis_if.tkeep, m_axis_if.tlast, m_axis_if.tuser}, 0);
    check_val("rst_status", {busy, done, cfg_err}, 0);
    check_val("rst_pkts_sent", pkts_sent, 0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;

    // 10 bytes, one packet: 3 beats with partial keep
    do_start(10, 1, 0, 1);
    check_val("t1_busy", busy, 1);
    check_val("t1_first_valid", m_axis_if.tvalid, 1);
    wait_done(50);
    check_val("t1_done_latency", done_cyc - last_hs_cyc, 1);
    check_val("t1_pkts_sent", pkts_sent, 1);

    // three single-beat packets back to back
    do_start(4, 3, 0, 1);
    wait_done(50);
    check_val("t2_valid_cycles", valid_cyc, 3);
    check_val("t2_gap", gap_meas, 0);
    check_val("t2_pkts_sent", pkts_sent, 3);

    // five idle cycles between packets
    do_start(8, 2, 5, 1);
    wait_done(80);
    check_val("t3_gap", gap_meas, 5);
    check_val("t3_pkts_sent", pkts_sent, 2);

    // random backpressure
    rdy_rand = 1'b1;
    do_start(16, 2, 0, 1);
    wait_done(400);
    check_val("t4_pkts_sent", pkts_sent, 2);
    rdy_rand = 1'b0;

    // bad config: zero length, then zero count
    do_start(0, 1, 3, 0);
    check_val("t5_cfg_err", cfg_err, 1);
    check_val("t5_busy", busy, 0);
    wait_done(10);
    check_val("t5_no_valid", valid_cyc, 0);
    do_start(4, 1, 0, 1);
    check_val("t5_cfg_err_clr", cfg_err, 0);
    wait_done(20);
    do_start(4, 0, 0, 0);
    check_val("t5_cfg_err_cnt0", cfg_err, 1);
    wait_done(10);
    check_val("t5_no_valid_cnt0", valid_cyc, 0);

    // reset while beat 2 of a 5-beat packet is presented
    begin
      int base, n;
      do_start(20, 1, 0, 1);
      base = hs_cnt;
      n = 0;
      while (hs_cnt < base + 2 && n < 50) begin
        @(negedge aclk);
        #1;
        n++;
      end
      check_val("t6_two_beats", hs_cnt - base, 2);
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      check_val("t6_tvalid", m_axis_if.tvalid, 0);
      check_val("t6_busy", busy, 0);
      check_val("t6_pkts_sent", pkts_sent, 0);
      exp_q.delete();
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      do_start(4, 1, 0, 1);
      wait_done(20);
      check_val("t6_pkts_after", pkts_sent, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
AXI4-Stream packet source that drives the slave side of the team's AXIS packet FIFO in simulation and on-chip loopback tests.
- Emits a programmed number of packets with a deterministic byte pattern, TLAST/TKEEP framing and a start-of-frame TUSER bit.
- Optional idle gaps between packets.
- Fully honours TREADY backpressure so packet-mode FIFO behaviour can be exercised end to end.

Parameters:
DATA_W, 32, TDATA width in bits; must be a multiple of 8.
KEEP_W, DATA_W/8, TKEEP width, one bit per byte lane.
USER_W, 1, TUSER width; bit 0 is SOF, upper bits are driven 0.
LEN_W, 16, width of the packet-length (bytes) field.
CNT_W, 16, width of the packet-count and sent-counter fields.
GAP_W, 8, width of the inter-packet gap field.

Ports:
aclk  in  1  clock, rising edge.
aresetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
cfg_len  in  LEN_W  packet length in bytes; captured at start.
cfg_count  in  CNT_W  number of packets; captured at start.
cfg_gap  in  GAP_W  idle cycles between packets; captured at start.
busy  out  1  high from the cycle after an accepted start until DONE.
done  out  1  one-cycle pulse when the run completes.
cfg_err  out  1  sticky until the next start; set when cfg_len==0 or cfg_count==0.
pkts_sent  out  CNT_W  packets completed in the current run.
m_axis_tvalid  out  1  AXIS valid.
m_axis_tready  in  1  AXIS ready.
m_axis_tdata  out  DATA_W  AXIS data, little-endian byte lanes.
m_axis_tkeep  out  KEEP_W  AXIS byte qualifiers.
m_axis_tlast  out  1  last beat of a packet.
m_axis_tuser  out  USER_W  bit 0 = first beat of a packet.

Behaviour:
- Reset: tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0, busy=0, done=0, cfg_err=0, pkts_sent=0, state=IDLE.
- Reset asserted mid-packet truncates the packet immediately with no completion; the run is not resumed.
- All outputs are registered.
- Handshake: a beat transfers when tvalid&&tready.
  - Once tvalid=1, tdata/tkeep/tlast/tuser are held stable until the transfer.
  - tvalid never drops without a transfer.
  - tvalid does not depend combinationally on tready.
- Beats per packet = ceil(cfg_len/KEEP_W).
- Byte-count arithmetic is done at LEN_W+1 bits, so cfg_len of all-ones does not wrap.
- Pattern:
  - Byte k of packet p (0-based) = (p[7:0] + k) mod 256.
  - Lane i of a beat carries byte beat_idx*KEEP_W + i.
- TKEEP:
  - All ones on non-final beats.
  - On the final beat, the low r bits set, where r = cfg_len - (beats-1)*KEEP_W (1..KEEP_W).
  - Masked lanes carry 0.
- tuser[0]=1 only on the first beat of each packet. tlast=1 only on the final beat. A 1-beat packet has both set.
- FSM:
  - IDLE: start && cfg_len!=0 && cfg_count!=0 -> latch cfg, clear pkts_sent and cfg_err, go to SEND. The first beat is valid the cycle after start (latency 1).
  - IDLE: start with zero len or count -> cfg_err=1, done pulse next cycle, stay IDLE.
  - SEND: present beats. On the final-beat handshake, increment pkts_sent.
    - If pkts_sent+1==count -> DONE.
    - Else if gap==0 -> next packet's first beat valid in the next cycle (back-to-back).
    - Else -> GAP.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND with the next packet.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- start outside IDLE is ignored. cfg_* changes after start have no effect.
- busy=1 in SEND and GAP.
- pkts_sent holds its final value after DONE until the next accepted start.
- Sustained tready=1 and gap=0 gives 100% throughput with no bubbles between packets.
- tready low for any number of cycles simply stalls the beat; no state advances.

Decomposition:
- Package axis_pkt_pkg: FSM state enum (IDLE, SEND, GAP, DONE); SOF_BIT constant = 0; function keep_from_bytes(r) returning a KEEP_W mask; function pattern_byte(p, k).
- One combinational sub-module, axis_pkt_beat_fmt: inputs are the base byte, beat index and remaining bytes; outputs are tdata, tkeep and tlast for the beat.
- The top module holds the FSM, counters and output registers.

Test Plan:
- KEEP_W=4, len=10, count=1, gap=0, tready=1.
  - Beats: 0x03020100 keep 1111 tuser=1; 0x07060504 keep 1111; 0x00000908 keep 0011 tlast=1.
  - done pulses 1 cycle after the last handshake; pkts_sent=1.
- len=4, count=3, gap=0, tready=1.
  - Three consecutive single-beat packets, each with tuser=1 and tlast=1: 0x03020100, 0x04030201, 0x05040302.
  - tvalid stays high for exactly 3 cycles.
- len=8, count=2, gap=5.
  - Exactly 5 cycles of tvalid=0 between the packet-0 tlast handshake and the packet-1 first beat.
- len=16, count=2, random tready (50%).
  - No tdata/tkeep/tlast/tuser change while tvalid&&!tready.
  - Received byte stream matches the pattern; pkts_sent=2.
- start with cfg_len=0.
  - cfg_err=1, done pulse, tvalid never asserted.
  - A following valid start clears cfg_err.
- aresetn low during beat 2 of a 5-beat packet.
  - tvalid=0 and busy=0 immediately; pkts_sent=0.
  - After reset release, a new start emits packet 0 from byte 0x00.
